// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI ADC emulator driving miso under cs; ADC_RESP_LFSR_EN swaps the ramp for a 16-bit LFSR
module adc_spi_responder #(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int RAMP_STEP  = 1,
  parameter bit IDLE_MISO  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_load,
  input  logic              pattern_en,
  output logic              miso,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [15:0]       frame_count
);
  localparam int MAXC = DATA_W > LEAD_ZEROS ? DATA_W : LEAD_ZEROS;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, LEAD, DATA, TRAIL} state_t;
  state_t state, state_n;
  logic cs_q, load_pend, used_pat, fall, last_lead, last_data, use_pend;
  logic [DATA_W-1:0] shift, shadow, pend_val, pat_val;
  logic [CW-1:0] bit_cnt;
`ifdef ADC_RESP_LFSR_EN
  logic [15:0] lfsr;
`else
  logic [DATA_W-1:0] ramp;
`endif
  always_comb begin
    fall = cs_q & ~cs;
    last_lead = bit_cnt == CW'(LEAD_ZEROS - 1);
    last_data = bit_cnt == CW'(DATA_W - 1);
    use_pend = load_pend | sample_load;
    pend_val = sample_load ? sample_data : shadow;
`ifdef ADC_RESP_LFSR_EN
    pat_val = lfsr[DATA_W-1:0];
`else
    pat_val = ramp;
`endif
    state_n = state;
    case (state)
      IDLE:    state_n = !fall ? IDLE : LEAD_ZEROS == 0 ? DATA : LEAD;
      LEAD:    state_n = cs ? IDLE : last_lead ? DATA : LEAD;
      DATA:    state_n = cs ? IDLE : last_data ? TRAIL : DATA;
      default: state_n = cs ? IDLE : TRAIL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cs_q <= 1'b1;
      miso <= IDLE_MISO;
      busy <= 1'b0;
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
      frame_count <= '0;
      shadow <= '0;
      shift <= '0;
      load_pend <= 1'b0;
      used_pat <= 1'b0;
      bit_cnt <= '0;
`ifdef ADC_RESP_LFSR_EN
      lfsr <= 16'hACE1;
`else
      ramp <= '0;
`endif
    end else begin
      state <= state_n;
      cs_q <= cs;
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
      if (sample_load) begin
        shadow <= sample_data;
        load_pend <= 1'b1;
      end
      if (state == IDLE) begin
        miso <= IDLE_MISO;
        if (fall) begin
          shift <= use_pend ? pend_val : pattern_en ? pat_val : shadow;
          used_pat <= ~use_pend & pattern_en;
          load_pend <= 1'b0;
          bit_cnt <= '0;
          busy <= 1'b1;
        end
      end else if (state == TRAIL) begin
        miso <= cs ? IDLE_MISO : 1'b0;
        busy <= ~cs;
      end else if (cs) begin
        miso <= IDLE_MISO;
        busy <= 1'b0;
        frame_abort <= 1'b1;
      end else if (state == LEAD) begin
        miso <= 1'b0;
        bit_cnt <= last_lead ? '0 : bit_cnt + CW'(1);
      end else begin
        miso <= shift[DATA_W-1];
        shift <= shift << 1;
        bit_cnt <= bit_cnt + CW'(1);
        if (last_data) begin
          frame_done <= 1'b1;
          frame_count <= frame_count + 16'd1;
`ifdef ADC_RESP_LFSR_EN
          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`else
          if (used_pat) ramp <= ramp + DATA_W'(RAMP_STEP);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed frames with hand-computed words, aborts, loads and counter wrap
module tb_adc_spi_responder;
  logic clk = 1'b0;
  logic reset, cs, sample_load, pattern_en, miso, busy, frame_done, frame_abort;
  logic [11:0] sample_data;
  logic [15:0] frame_count;
  int total = 0;
  int passed = 0;
  logic [15:0] lf = 16'hACE1;
  logic [11:0] rp = '0;
  always #5 clk = ~clk;
  adc_spi_responder dut (
    .clk(clk), .reset(reset), .cs(cs), .sample_data(sample_data), .sample_load(sample_load),
    .pattern_en(pattern_en), .miso(miso), .busy(busy), .frame_done(frame_done),
    .frame_abort(frame_abort), .frame_count(frame_count)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] pat();
`ifdef ADC_RESP_LFSR_EN
    return lf[11:0];
`else
    return rp;
`endif
  endfunction
  task automatic adv(input bit used);
`ifdef ADC_RESP_LFSR_EN
    lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
`else
    if (used) rp = rp + 12'd1;
`endif
  endtask
  task automatic load(input logic [11:0] v);
    sample_load = 1'b1;
    sample_data = v;
    step;
    sample_load = 1'b0;
  endtask
  task automatic frame(input string tag, input logic [11:0] exp, input bit used,
                       input bit sl, input logic [11:0] ld, input bit ml, input logic [11:0] mid);
    logic [3:0] lead;
    logic [11:0] word;
    lead = '0;
    word = '0;
    cs = 1'b0;
    if (sl) begin
      sample_load = 1'b1;
      sample_data = ld;
    end
    step;
    sample_load = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    for (int n = 1; n <= 16; n++) begin
      if (ml && n == 8) begin
        sample_load = 1'b1;
        sample_data = mid;
      end
      step;
      sample_load = 1'b0;
      if (n <= 4) lead = {lead[2:0], miso};
      else word = {word[10:0], miso};
      if (n == 15) chk({tag, ".early_done"}, frame_done, 0);
    end
    chk({tag, ".lead"}, lead, 0);
    chk({tag, ".word"}, word, exp);
    chk({tag, ".done"}, frame_done, 1);
    chk({tag, ".no_abort"}, frame_abort, 0);
    step;
    chk({tag, ".trail_miso"}, miso, 0);
    chk({tag, ".done_1cyc"}, frame_done, 0);
    chk({tag, ".trail_busy"}, busy, 1);
    cs = 1'b1;
    step;
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".idle_miso"}, miso, 0);
    adv(used);
  endtask
  task automatic abort_frame(input string tag);
    cs = 1'b0;
    step;
    repeat (7) step;
    cs = 1'b1;
    step;
    chk({tag, ".abort"}, frame_abort, 1);
    chk({tag, ".miso"}, miso, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".no_done"}, frame_done, 0);
    step;
    chk({tag, ".abort_1cyc"}, frame_abort, 0);
  endtask
  initial begin
    reset = 1'b1;
    cs = 1'b1;
    sample_load = 1'b0;
    sample_data = '0;
    pattern_en = 1'b0;
    repeat (3) step;
    chk("rst.miso", miso, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", frame_done, 0);
    chk("rst.abort", frame_abort, 0);
    chk("rst.count", frame_count, 0);
    reset = 1'b0;
    step;
    load(12'hA5C);
    frame("t1", 12'hA5C, 0, 0, 0, 0, 0);
    chk("t1.count", frame_count, 1);
    frame("t1_repeat", 12'hA5C, 0, 0, 0, 0, 0);
    pattern_en = 1'b1;
    frame("t2a", pat(), 1, 0, 0, 0, 0);
    frame("t2b", pat(), 1, 0, 0, 0, 0);
    frame("t2c", pat(), 1, 0, 0, 0, 0);
    chk("t2.count", frame_count, 5);
    abort_frame("t3");
    chk("t3.count", frame_count, 5);
    frame("t3_reuse", pat(), 1, 0, 0, 0, 0);
    frame("t4_bypass", 12'h123, 0, 1, 12'h123, 1, 12'h456);
    frame("t4_pend", 12'h456, 0, 0, 0, 0, 0);
    frame("t4_ramp", pat(), 1, 0, 0, 0, 0);
    load(12'h111);
    load(12'h222);
    frame("t4_last_wins", 12'h222, 0, 0, 0, 0, 0);
    chk("t4.count", frame_count, 10);
`ifndef ADC_RESP_LFSR_EN
    force dut.ramp = 12'hFFF;
    step;
    release dut.ramp;
    rp = 12'hFFF;
    frame("t2_fff", 12'hFFF, 1, 0, 0, 0, 0);
    frame("t2_wrap", 12'h000, 1, 0, 0, 0, 0);
`endif
    force dut.frame_count = 16'hFFFF;
    step;
    release dut.frame_count;
    frame("t6", pat(), 1, 0, 0, 0, 0);
    chk("t6.count_wrap", frame_count, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
